// File: rtl/decoder_strobe_pkg.sv
// Shared types for the strobe decoder: controller states and the counter sizing helper.
package decoder_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } strobe_state_t;

    // Width able to hold max(pulsew, gapw, 2) - 1; never returns zero.
    function automatic int cnt_width(input int pulsew, input int gapw);
        int m;
        m = 2;
        if (pulsew > m) m = pulsew;
        if (gapw > m) m = gapw;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational select-to-one-hot decode with enable and a range-valid flag.
module decoder_onehot #(
    parameter int SELW = 3,
    parameter int NOUT = 8
) (
    input  logic            en,
    input  logic [0:SELW-1] sel,
    output logic [0:NOUT-1] onehot,
    output logic            valid
);

    localparam logic [SELW:0] NOUT_V = (SELW+1)'(NOUT);

    always_comb begin
        valid = 1'b1;
        // A full decode cannot go out of range, so the compare is dropped entirely.
        if (NOUT < (2 ** SELW)) valid = ({1'b0, sel} < NOUT_V);
        onehot = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (en && valid && (sel == SELW'(i))) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_strobe.sv
// Registered one-hot strobe generator: pulse or level strobes with a forced dead gap,
// out-of-range rejection and a one-cycle ack per request.
//
// state    | meaning
// ST_IDLE  | q=0, waiting for req; accepts or rejects on the sampling edge
// ST_PULSE | q held, counting down PULSEW cycles
// ST_HOLD  | q held while req stays high
// ST_GAP   | q=0, counting down GAPW dead cycles
module decoder_strobe
    import decoder_strobe_pkg::*;
#(
    parameter int SELW   = 3,
    parameter int NOUT   = 8,
    parameter int PULSEW = 1,
    parameter int GAPW   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [0:SELW-1] sel,
    input  logic            mode,
    output logic            ack,
    output logic            err,
    output logic            busy,
    output logic [0:NOUT-1] q
);

    localparam int CW = cnt_width(PULSEW, GAPW);
    localparam strobe_state_t ST_AFTER = (GAPW > 0) ? ST_GAP : ST_IDLE;
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSEW - 1);
    localparam logic [CW-1:0] GAP_LD   = (GAPW > 0) ? CW'(GAPW - 1) : '0;

    strobe_state_t   state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [0:NOUT-1] q_nx;
    logic            ack_nx, err_nx;
    logic [0:NOUT-1] dec;
    logic            sel_ok;

    decoder_onehot #(
        .SELW(SELW),
        .NOUT(NOUT)
    ) u_dec (
        .en    (req && (state == ST_IDLE)),
        .sel   (sel),
        .onehot(dec),
        .valid (sel_ok)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        q_nx     = q;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                q_nx = '0;
                if (req) begin
                    ack_nx = 1'b1;
                    if (!sel_ok) begin
                        err_nx = 1'b1;
                    end else begin
                        q_nx = dec;
                        if (mode) begin
                            state_nx = ST_HOLD;
                        end else begin
                            state_nx = ST_PULSE;
                            cnt_nx   = PULSE_LD;
                        end
                    end
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    q_nx     = '0;
                    state_nx = ST_AFTER;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (!req) begin
                    q_nx     = '0;
                    state_nx = ST_AFTER;
                    cnt_nx   = GAP_LD;
                end
            end
            ST_GAP: begin
                q_nx = '0;
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx = cnt - CW'(1);
            end
            default: begin
                q_nx     = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q     <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            ack   <= ack_nx;
            err   <= err_nx;
        end
    end

    assign busy = (state != ST_IDLE);

    a_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(q));
    a_busy:     assert property (@(posedge clk) disable iff (!rst_n) busy == (state != ST_IDLE));
    a_err_ack:  assert property (@(posedge clk) disable iff (!rst_n) err |-> ack);
    a_err_noq:  assert property (@(posedge clk) disable iff (!rst_n) err |-> (q == '0));

endmodule

// File: doc/decoder_strobe.md
Name: decoder_strobe

Overview:
- Parametrised, registered successor to the combinational 3-to-8 enable decoder.
- Turns a select code plus a request into a one-hot strobe on one of NOUT outputs.
- Strobe is either a fixed-width pulse or a level held for as long as the request stays high.
- Enforces a minimum dead gap between strobes, reports out-of-range selects, and handshakes each request with a one-cycle ack. Used by EBOX/MBOX control logic to fire timed register-load and bus-enable strobes.

Parameters:
- SELW, 3, select width in bits.
- NOUT, 8, number of strobe outputs; 1 <= NOUT <= 2**SELW.
- PULSEW, 1, strobe width in cycles in pulse mode; >= 1.
- GAPW, 0, forced all-zero cycles after each strobe before the next request is accepted; >= 0.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- req  in  1  request; level-sensitive, held until ack.
- sel  in  [0:SELW-1]  select code; bit 0 is the MSB.
- mode  in  1  0 = pulse mode, 1 = level mode; sampled only at acceptance.
- ack  out  1  one-cycle acknowledge of an accepted or rejected request.
- err  out  1  one-cycle flag: request rejected because sel >= NOUT.
- busy  out  1  high whenever state is not IDLE.
- q  out  [0:NOUT-1]  registered one-hot strobes; q[i] corresponds to sel == i, so q[0] is the leftmost bit.

Behaviour:
- Reset: one clock with rst_n=0 forces state=IDLE, q=0, ack=0, err=0, busy=0, counters=0, at that edge. This applies mid-pulse and mid-gap; no partial strobe survives.
- States: IDLE, PULSE, HOLD, GAP.
- IDLE: req=0 -> stay, q=0. req=1 sampled at edge k:
  - sel >= NOUT: ack=1 and err=1 during cycle k+1 only, q stays 0, stay IDLE.
  - Otherwise: latch sel and mode. In cycle k+1, q = one-hot of the latched sel, ack=1, busy=1. Go to PULSE (mode=0, counter=PULSEW-1) or HOLD (mode=1).
- Latency: req to q is exactly 1 cycle. ack and the first strobe cycle coincide.
- PULSE: q held. Counter==0 -> at next edge q=0 and go to GAP (GAPW>0, counter=GAPW-1) or IDLE (GAPW==0). Otherwise decrement. q high for exactly PULSEW cycles.
- HOLD: q held while req=1; sel and mode changes are ignored. req sampled 0 -> q=0 at that edge, then GAP or IDLE as above. Minimum strobe width is 1 cycle regardless of PULSEW.
- GAP: q=0, busy=1, for exactly GAPW cycles, then IDLE.
- While busy, req is ignored: no ack, no err.
- A requester that keeps req high after ack in pulse mode gets a fresh strobe as soon as IDLE is re-entered. With GAPW=0, back-to-back strobes are separated by one IDLE cycle.
- At most one bit of q is ever set. ack and q-rising are always simultaneous for valid requests.
- err is never asserted together with any q bit.
- Width rules: the PULSE/GAP counter width is clog2(max(PULSEW,GAPW,2)). The comparison sel >= NOUT is unsigned. When NOUT == 2**SELW the comparison is statically false.
- Assertions: onehot0(q); busy == (state != IDLE); err implies ack.

Decomposition:
- The shared ebox package gets the state enum (IDLE, PULSE, HOLD, GAP) and a clog2-safe counter-width function.
- One natural sub-module: decoder_onehot, a purely combinational, parametrised SELW/NOUT one-hot decode with enable and a range-valid output. decoder_strobe registers its output.

Test Plan (SELW=3, NOUT=6, PULSEW=3, GAPW=2 unless stated):
- Reset, then req=1, sel=2, mode=0 at edge 0 -> cycles 1-3 q=6'b001000; ack=1 in cycle 1 only; busy in cycles 1-5; q=0 in cycles 4-5; IDLE in cycle 6.
- req=1, sel=7 -> cycle 1 ack=1, err=1, q=0, busy=0; a second request sel=0 at edge 1 gives q=6'b100000 in cycle 2.
- mode=1, sel=5, req held for 6 cycles then dropped -> q=6'b000001 for cycles 1-6, q=0 from cycle 7, 2 gap cycles. Toggling sel during hold has no effect.
- req held continuously, sel=1, GAPW=0, PULSEW=1 -> q[1] pulses every 2 cycles, with one ack per pulse.
- rst_n=0 in cycle 2 of a 3-cycle pulse -> q=0, busy=0, ack=0 from that edge. A new req after release gives a normal 1-cycle latency.
- NOUT=8, SELW=3, PULSEW=1: sweep sel 0..7 -> q = 8'b1000_0000 through 8'b0000_0001, err never set.
